// File: rtl/xbar_pkg.sv
// Shared crossbar arbitration types and the round-robin selection rule.
// The rule is shared by the source-side and slave-side arbiters.
package xbar_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, POP, HOLD} arb_state_t;

  localparam int MAX_SRC = 32;
  localparam int MAX_SW  = 5;

  // First requester after 'last', wrapping modulo num_src; returns 'last' if none.
  function automatic int rr_next(input logic [MAX_SRC-1:0] req,
                                 input int                 num_src,
                                 input int                 last);
    int   idx;
    int   cand;
    logic found;
    idx   = last;
    found = 1'b0;
    for (int k = 1; k <= MAX_SRC; k++) begin
      cand = (last + k >= num_src) ? (last + k - num_src) : (last + k);
      if (!found && (k <= num_src) && req[cand[MAX_SW-1:0]]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/xbar_rr_arbiter_if.sv
// Fifo-side and slave-side signals of the crossbar round-robin arbiter.
interface xbar_rr_arbiter_if #(
  parameter int NUM_SRC = 4,
  parameter int DWIDTH  = 32
);
  localparam int SW = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0]        src_not_empty;
  logic [NUM_SRC*DWIDTH-1:0] src_data;
  logic [NUM_SRC-1:0]        src_pop;
  logic [DWIDTH-1:0]         m_data;
  logic [SW-1:0]             m_src_id;
  logic                      m_valid;
  logic                      m_ready;

  modport master (
    input  src_not_empty, src_data, m_ready,
    output src_pop, m_data, m_src_id, m_valid
  );

  modport slave (
    output src_not_empty, src_data, m_ready,
    input  src_pop, m_data, m_src_id, m_valid
  );
endinterface

// File: rtl/rr_priority_enc.sv
// Rotated priority encoder: picks the first requester after last_grant_i, with wrap.
module rr_priority_enc
  import xbar_pkg::*;
#(
  parameter  int NUM_SRC = 4,
  localparam int SW      = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [SW-1:0]      last_grant_i,
  output logic [SW-1:0]      gnt_idx_o,
  output logic               gnt_valid_o
);

  logic [MAX_SRC-1:0] req_ext_s;

  // Widen the request vector to the shared function width and select.
  always_comb begin
    req_ext_s              = '0;
    req_ext_s[NUM_SRC-1:0] = req_i;
    gnt_idx_o              = SW'(rr_next(req_ext_s, NUM_SRC, int'(last_grant_i)));
    gnt_valid_o            = |req_i;
  end

endmodule

// File: rtl/xbar_rr_arbiter.sv
// Round-robin arbiter/mux behind the per-source fifos: pops one word at a time
// and holds it on a registered valid/ready output tagged with its source index.
module xbar_rr_arbiter
  import xbar_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int DWIDTH  = 32
) (
  input  logic              aclk,
  input  logic              aresetn,
  xbar_rr_arbiter_if.master bus
);

  localparam int SW = $clog2(NUM_SRC);
  localparam logic [NUM_SRC-1:0] POP_ONE = NUM_SRC'(1);

  arb_state_t         state_q;
  logic [SW-1:0]      sel_q;
  logic [SW-1:0]      last_grant_q;
  logic [NUM_SRC-1:0] src_pop_q;
  logic [DWIDTH-1:0]  m_data_q;
  logic [SW-1:0]      m_src_id_q;
  logic               m_valid_q;

  logic [SW-1:0]      gnt_idx_s;
  logic               gnt_valid_s;
  logic [DWIDTH-1:0]  sel_data_s;

  rr_priority_enc #(.NUM_SRC(NUM_SRC)) u_enc (
    .req_i        (bus.src_not_empty),
    .last_grant_i (last_grant_q),
    .gnt_idx_o    (gnt_idx_s),
    .gnt_valid_o  (gnt_valid_s)
  );

  // Head word of the selected fifo.
  always_comb begin
    sel_data_s = bus.src_data[int'(sel_q)*DWIDTH +: DWIDTH];
  end

  // Arbitration FSM; the pop pulse is registered on SETTLE exit so it spans exactly POP.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      last_grant_q <= SW'(NUM_SRC - 1);
      src_pop_q    <= '0;
      m_data_q     <= '0;
      m_src_id_q   <= '0;
      m_valid_q    <= 1'b0;
    end else begin
      src_pop_q <= '0;
      case (state_q)
        IDLE: begin
          if (gnt_valid_s) begin
            sel_q   <= gnt_idx_s;
            state_q <= SETTLE;
          end
        end
        SETTLE: begin
          src_pop_q <= POP_ONE << sel_q;
          state_q   <= POP;
        end
        POP: begin
          m_data_q     <= sel_data_s;
          m_src_id_q   <= sel_q;
          m_valid_q    <= 1'b1;
          last_grant_q <= sel_q;
          state_q      <= HOLD;
        end
        HOLD: begin
          if (m_valid_q && bus.m_ready) begin
            m_valid_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: begin
          m_valid_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign bus.src_pop  = src_pop_q;
  assign bus.m_data   = m_data_q;
  assign bus.m_src_id = m_src_id_q;
  assign bus.m_valid  = m_valid_q;

endmodule
